// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port target.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddr    = 3'd1,
        StAckAddr = 3'd2,
        StReg     = 3'd3,
        StAckReg  = 3'd4,
        StData    = 3'd5,
        StAckData = 3'd6,
        StIgnore  = 3'd7
    } state_e;

    localparam logic [6:0]  DEV_ADDR_DEF  = 7'b0011010;
    localparam logic [6:0]  RESET_REG_DEF = 7'h0F;
    localparam int unsigned REG_W         = 9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges and START/STOP.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl   = scl_sync_q[1];
    assign o_sda = sda_sync_q[1];

    assign o_scl_rise = scl & ~scl_hist_q;
    assign o_scl_fall = ~scl & scl_hist_q;
    // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples
    assign o_start    = scl & scl_hist_q & sda_hist_q & ~o_sda;
    assign o_stop     = scl & scl_hist_q & ~sda_hist_q & o_sda;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target shadowing the WM8731 control registers; ACKs valid writes and
// commits each 9-bit value into a local register file.
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEF,
    parameter int unsigned NUM_REGS  = 10,
    parameter logic [6:0]  RESET_REG = RESET_REG_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_scl,
    input  logic                      i_sda,
    output logic                      o_sda_oe,
    output logic                      o_wr_valid,
    output logic [6:0]                o_wr_addr,
    output logic [8:0]                o_wr_data,
    output logic [NUM_REGS*REG_W-1:0] o_regs,
    output logic [7:0]                o_nack_count,
    output logic [2:0]                o_state
);

    logic scl_rise, scl_fall, bus_start, bus_stop, sda;

    i2c_bus_sync u_bus_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (bus_start),
        .o_stop     (bus_stop),
        .o_sda      (sda)
    );

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic                      byte_done_q, byte_done_d;
    logic [7:0]                shift_q, shift_d;
    logic [6:0]                reg_addr_q, reg_addr_d;
    logic                      msb_q, msb_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [6:0]                wr_addr_q, wr_addr_d;
    logic [8:0]                wr_data_q, wr_data_d;
    logic [NUM_REGS*REG_W-1:0] regs_q, regs_d;
    logic [7:0]                nack_q, nack_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            byte_done_q <= 1'b0;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            msb_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            regs_q      <= '0;
            nack_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            reg_addr_q  <= reg_addr_d;
            msb_q       <= msb_d;
            sda_oe_q    <= sda_oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
            nack_q      <= nack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_done_d = byte_done_q;
        shift_d     = shift_q;
        reg_addr_d  = reg_addr_q;
        msb_d       = msb_q;
        sda_oe_d    = sda_oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;
        nack_d      = nack_q;

        if (bus_stop) begin
            state_d     = StIdle;
            sda_oe_d    = 1'b0;
            cnt_d       = '0;
            byte_done_d = 1'b0;
        end else if (bus_start) begin
            state_d     = StAddr;
            sda_oe_d    = 1'b0;
            cnt_d       = '0;
            byte_done_d = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StReg, StData: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        // Falling edge closing bit 8: decide ACK and drive it for the 9th clock
                        byte_done_d = 1'b0;
                        cnt_d       = '0;
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                state_d  = StAckAddr;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                                if (shift_q[7:1] == DEV_ADDR && nack_q != 8'hFF) begin
                                    nack_d = nack_q + 8'd1;
                                end
                            end
                        end else if (state_q == StReg) begin
                            reg_addr_d = shift_q[7:1];
                            msb_d      = shift_q[0];
                            state_d    = StAckReg;
                            sda_oe_d   = 1'b1;
                        end else if (32'(reg_addr_q) < NUM_REGS || reg_addr_q == RESET_REG) begin
                            state_d    = StAckData;
                            sda_oe_d   = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = reg_addr_q;
                            wr_data_d  = {msb_q, shift_q};
                            if (reg_addr_q == RESET_REG) begin
                                regs_d = '0;
                            end else begin
                                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                                    if (32'(reg_addr_q) == k) begin
                                        regs_d[k*REG_W +: REG_W] = {msb_q, shift_q};
                                    end
                                end
                            end
                        end else begin
                            state_d = StIgnore;
                            if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
                        end
                    end
                end
                StAckAddr, StAckReg, StAckData: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (state_q == StAckAddr)     state_d = StReg;
                        else if (state_q == StAckReg) state_d = StData;
                        else                          state_d = StIgnore;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_oe     = sda_oe_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_regs       = regs_q;
    assign o_nack_count = nack_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bus-level bench: a bit-banged I2C master drives writes; committed writes are scoreboarded.
module tb_i2c_codec_target;

    localparam logic [6:0] DEV = 7'b0011010;
    localparam int         Q   = 6;
    localparam int         H   = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m, sda_m;
    logic        sda_bus;
    logic        sda_oe, wr_valid;
    logic [6:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [89:0] regs;
    logic [7:0]  nack_cnt;
    logic [2:0]  state;

    int          total = 0;
    int          bad   = 0;
    int          pulses = 0;
    logic [15:0] exp_q[$];
    logic [89:0] model_regs = '0;
    logic [7:0]  model_nack = '0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_scl        (scl_m),
        .i_sda        (sda_bus),
        .o_sda_oe     (sda_oe),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_regs       (regs),
        .o_nack_count (nack_cnt),
        .o_state      (state)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 1, 0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", wr_addr, e[15:9]);
                check_eq("wr_data", wr_data, e[8:0]);
                if (e[15:9] == 7'h0F) check_eq("wr_regs_clr", regs, 0);
                else check_eq("wr_regs_slice", regs[int'(e[15:9])*9 +: 9], e[8:0]);
            end
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b1; wait_clk(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_clk(Q);
            scl_m = 1'b1; wait_clk(H);
            scl_m = 1'b0; wait_clk(Q);
        end
    endtask

    task automatic ack_clock(output logic ack);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(H);
        ack = ~sda_bus;
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        logic ack;
        send_bits(b, 8);
        ack_clock(ack);
        check_eq(tag, ack, exp_ack);
    endtask

    task automatic write_txn(input logic [6:0] ra, input logic [8:0] d);
        logic valid;
        valid = (ra < 7'd10) || (ra == 7'h0F);
        i2c_start();
        send_byte_chk("ack_addr", {DEV, 1'b0}, 1'b1);
        send_byte_chk("ack_reg", {ra, d[8]}, 1'b1);
        if (valid) begin
            exp_q.push_back({ra, d});
            if (ra == 7'h0F) model_regs = '0;
            else model_regs[int'(ra)*9 +: 9] = d;
        end else begin
            model_nack++;
        end
        send_byte_chk("ack_data", d[7:0], valid);
        i2c_stop();
    endtask

    task automatic check_idle(input string tag);
        wait_clk(4);
        check_eq({tag, "_state"}, state, 0);
        check_eq({tag, "_oe"}, sda_oe, 0);
        check_eq({tag, "_regs"}, regs, model_regs);
        check_eq({tag, "_nack"}, nack_cnt, model_nack);
        check_eq({tag, "_sb"}, exp_q.size(), 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] init_vals [10];
        init_vals = '{9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                      9'h006, 9'h062, 9'h04A, 9'h000, 9'h001};
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(5);
        check_eq("rst_state", state, 0);
        check_eq("rst_oe", sda_oe, 0);
        check_eq("rst_valid", wr_valid, 0);
        check_eq("rst_waddr", wr_addr, 0);
        check_eq("rst_wdata", wr_data, 0);
        check_eq("rst_regs", regs, 0);
        check_eq("rst_nack", nack_cnt, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // Single write
        write_txn(7'd4, 9'h015);
        check_eq("reg4", regs[44:36], 9'h015);
        check_idle("single");

        // Full init sequence
        for (int i = 0; i < 10; i++) write_txn(7'(i), init_vals[i]);
        check_idle("init");
        check_eq("pulses_init", pulses, 11);

        // Foreign address: nothing acknowledged, nothing counted
        i2c_start();
        send_byte_chk("ack_addr_1b", {7'h1B, 1'b0}, 1'b0);
        send_byte_chk("ack_reg_1b", {7'd1, 1'b0}, 1'b0);
        send_byte_chk("ack_data_1b", 8'hAA, 1'b0);
        i2c_stop();
        check_idle("foreign");

        // Read request to our address is NACKed and counted
        i2c_start();
        model_nack++;
        send_byte_chk("ack_addr_rd", {DEV, 1'b1}, 1'b0);
        i2c_stop();
        check_idle("read");

        // Out-of-range register, then the clear-all register
        write_txn(7'h0C, 9'h1FF);
        check_idle("oor");
        write_txn(7'h0F, 9'h000);
        check_idle("clear");

        // STOP after register byte, then repeated START in the middle of the data byte
        i2c_start();
        send_byte_chk("ack_addr_p", {DEV, 1'b0}, 1'b1);
        send_byte_chk("ack_reg_p", {7'd2, 1'b0}, 1'b1);
        i2c_stop();
        check_idle("partial");
        i2c_start();
        send_byte_chk("ack_addr_r", {DEV, 1'b0}, 1'b1);
        send_byte_chk("ack_reg_r", {7'd3, 1'b1}, 1'b1);
        send_bits(8'hC3, 4);
        i2c_start();
        send_byte_chk("ack_addr_r2", {DEV, 1'b0}, 1'b0 | 1'b1);
        send_byte_chk("ack_reg_r2", {7'd7, 1'b1}, 1'b1);
        exp_q.push_back({7'd7, 9'h15A});
        model_regs[7*9 +: 9] = 9'h15A;
        send_byte_chk("ack_data_r2", 8'h5A, 1'b1);
        i2c_stop();
        check_idle("restart");

        // Reset while the register byte is being acknowledged
        write_txn(7'd5, 9'h0C3);
        i2c_start();
        send_byte_chk("ack_addr_x", {DEV, 1'b0}, 1'b1);
        send_bits({7'd6, 1'b0}, 8);
        wait_clk(Q - 1);
        check_eq("ackreg_oe", sda_oe, 1);
        check_eq("ackreg_state", state, 4);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_oe", sda_oe, 0);
        check_eq("arst_state", state, 0);
        check_eq("arst_regs", regs, 0);
        model_regs = '0;
        model_nack = '0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        i2c_stop();
        check_idle("post_rst");
        write_txn(7'd9, 9'h1A5);
        check_idle("final");
        check_eq("pulses_total", pulses, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
